// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg
// Purpose: shared definitions for the control-bundle pipeline: bundle width,
// bundle field positions, NZCV flag positions and ARM condition codes.
// Ports: none (package).
package ctrl_pipe_pkg;

  localparam int CTRL_W = 7;

  // Bundle layout: {flag_write[1:0], branch, mem_write, reg_write, pc_src, mem_to_reg}
  localparam int B_MEM_TO_REG = 0;
  localparam int B_PC_SRC     = 1;
  localparam int B_REG_WRITE  = 2;
  localparam int B_MEM_WRITE  = 3;
  localparam int B_BRANCH     = 4;
  localparam int B_FW_CV      = 5;
  localparam int B_FW_NZ      = 6;

  // NZCV bit positions inside a 4-bit flag word
  localparam int F_V = 0;
  localparam int F_C = 1;
  localparam int F_Z = 2;
  localparam int F_N = 3;

  // Side-effecting bundle bits that are dropped when the condition fails
  localparam logic [CTRL_W-1:0] GATED_MASK =
    CTRL_W'((1 << B_REG_WRITE) | (1 << B_MEM_WRITE) | (1 << B_PC_SRC));

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_code_t;

endpackage

// File: rtl/cond_eval.sv
// cond_eval
// Purpose: combinational ARM condition-code check of a 4-bit condition
// against an NZCV flag word.
// Ports:
//   cond  in  4  condition field
//   flags in  4  NZCV flags
//   pass  out 1  condition holds
module cond_eval
  import ctrl_pipe_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[F_N];
  assign z = flags[F_Z];
  assign c = flags[F_C];
  assign v = flags[F_V];

  // 1111 is treated like AL so that an unused encoding never blocks execution
  always_comb begin
    pass = 1'b1;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_gen.sv
// ctrl_pipe_gen
// Purpose: carries decoded control bundles from D through NSTAGES post-decode
// stages (E .. W), stretching E for multicycle ops, gating side effects on the
// condition code and maintaining the architectural NZCV flags.
// Ports:
//   clk            in   1            clock, rising edge
//   reset          in   1            asynchronous reset, active low
//   valid_d        in   1            D holds a real instruction
//   ctrl_d         in   7            decoded bundle of D
//   cond_d         in   4            condition field of D
//   mc_d           in   1            D is a multicycle op
//   stall_d        in   1            hazard unit holds D, E gets a bubble
//   flush_e        in   1            clear E at next edge
//   alu_flags_e    in   4            NZCV from the ALU in E
//   ctrl_q         out  7*NSTAGES    per-stage bundle, stage k at [7k+6:7k]
//   busy_e         out  1            E holds an unfinished multicycle op
//   cond_ex_e      out  1            condition of E passes
//   branch_taken_e out  1            branch in E taken this cycle
//   flags_q        out  4            architectural NZCV
//   pc_wr_pending  out  1            PC write in flight in D or stages 0..NSTAGES-2
module ctrl_pipe_gen
  import ctrl_pipe_pkg::*;
#(
  parameter int NSTAGES = 3,
  parameter int MC_LAT  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_d,
  input  logic [CTRL_W-1:0]           ctrl_d,
  input  logic [3:0]                  cond_d,
  input  logic                        mc_d,
  input  logic                        stall_d,
  input  logic                        flush_e,
  input  logic [3:0]                  alu_flags_e,
  output logic [CTRL_W*NSTAGES-1:0]   ctrl_q,
  output logic                        busy_e,
  output logic                        cond_ex_e,
  output logic                        branch_taken_e,
  output logic [3:0]                  flags_q,
  output logic                        pc_wr_pending
);

  localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

  // stage_ctrl[0] is E (ungated); later stages hold already-gated bundles
  logic [CTRL_W-1:0] stage_ctrl [NSTAGES];
  logic              valid_e;
  logic [3:0]        cond_e;
  logic              mc_e;
  logic [CNT_W-1:0]  cnt;

  logic              cond_pass;
  logic              complete_e;
  logic [CTRL_W-1:0] gated_e;
  logic [CTRL_W-1:0] s1_in;
  logic              pend;

  cond_eval u_cond_eval (
    .cond  (cond_e),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  assign busy_e         = valid_e & mc_e & (cnt != '0);
  assign cond_ex_e      = valid_e & cond_pass;
  assign complete_e     = valid_e & ~busy_e;
  assign branch_taken_e = complete_e & stage_ctrl[0][B_BRANCH] & cond_ex_e;

  // A failing condition keeps flag_write/branch/mem_to_reg visible but drops
  // the architectural side effects.
  assign gated_e = cond_ex_e ? stage_ctrl[0] : (stage_ctrl[0] & ~GATED_MASK);
  assign s1_in   = complete_e ? gated_e : '0;

  // E load priority: flush, then hold while busy, then bubble on stall/invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NSTAGES; k++) begin
        stage_ctrl[k] <= '0;
      end
      valid_e <= 1'b0;
      cond_e  <= '0;
      mc_e    <= 1'b0;
      cnt     <= '0;
    end else begin
      if (flush_e) begin
        stage_ctrl[0] <= '0;
        valid_e       <= 1'b0;
        cond_e        <= '0;
        mc_e          <= 1'b0;
        cnt           <= '0;
      end else if (busy_e) begin
        cnt <= cnt - 1'b1;
      end else if (stall_d || !valid_d) begin
        stage_ctrl[0] <= '0;
        valid_e       <= 1'b0;
        cond_e        <= '0;
        mc_e          <= 1'b0;
        cnt           <= '0;
      end else begin
        stage_ctrl[0] <= ctrl_d;
        valid_e       <= 1'b1;
        cond_e        <= cond_d;
        mc_e          <= mc_d;
        cnt           <= mc_d ? CNT_W'(MC_LAT - 1) : '0;
      end
      stage_ctrl[1] <= s1_in;
      for (int k = 2; k < NSTAGES; k++) begin
        stage_ctrl[k] <= stage_ctrl[k-1];
      end
    end
  end

  // Flags commit only when E completes with a passing condition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else if (complete_e && cond_ex_e) begin
      if (stage_ctrl[0][B_FW_NZ]) begin
        flags_q[F_N] <= alu_flags_e[F_N];
        flags_q[F_Z] <= alu_flags_e[F_Z];
      end
      if (stage_ctrl[0][B_FW_CV]) begin
        flags_q[F_C] <= alu_flags_e[F_C];
        flags_q[F_V] <= alu_flags_e[F_V];
      end
    end
  end

  // E shows nothing while its op is still running so consumers never act early.
  assign ctrl_q[CTRL_W-1:0] = busy_e ? '0 : stage_ctrl[0];

  genvar g;
  generate
    for (g = 1; g < NSTAGES; g++) begin : g_ctrl_q
      assign ctrl_q[g*CTRL_W +: CTRL_W] = stage_ctrl[g];
    end
  endgenerate

  // D is outside this block's reset, so its contribution is masked by reset.
  always_comb begin
    pend = valid_d & ctrl_d[B_PC_SRC];
    for (int k = 0; k < NSTAGES - 1; k++) begin
      pend = pend | stage_ctrl[k][B_PC_SRC];
    end
    pc_wr_pending = reset & pend;
  end

endmodule

// File: tb/tb_ctrl_pipe_gen.sv
// tb_ctrl_pipe_gen
// Purpose: self-checking bench for ctrl_pipe_gen with a cycle model of E and
// a scoreboard of bundles entering stage 1, popped as they reach W.
// Ports: none (testbench top).
module tb_ctrl_pipe_gen;

  localparam int NSTAGES = 3;
  localparam int MC_LAT  = 4;
  localparam int W       = 7;

  logic                   clk;
  logic                   reset;
  logic                   valid_d;
  logic [W-1:0]           ctrl_d;
  logic [3:0]             cond_d;
  logic                   mc_d;
  logic                   stall_d;
  logic                   flush_e;
  logic [3:0]             alu_flags_e;
  logic [W*NSTAGES-1:0]   ctrl_q;
  logic                   busy_e;
  logic                   cond_ex_e;
  logic                   branch_taken_e;
  logic [3:0]             flags_q;
  logic                   pc_wr_pending;

  int n_checks = 0;
  int n_pass   = 0;

  // Model of E and flags
  logic         m_valid;
  logic [W-1:0] m_ctrl;
  logic [3:0]   m_cond;
  logic         m_mc;
  int           m_cnt;
  logic [3:0]   m_flags;
  // Bundles in stages NSTAGES-2 .. 1 (front is the oldest)
  logic [W-1:0] sb[$];

  ctrl_pipe_gen #(.NSTAGES(NSTAGES), .MC_LAT(MC_LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_d        (valid_d),
    .ctrl_d         (ctrl_d),
    .cond_d         (cond_d),
    .mc_d           (mc_d),
    .stall_d        (stall_d),
    .flush_e        (flush_e),
    .alu_flags_e    (alu_flags_e),
    .ctrl_q         (ctrl_q),
    .busy_e         (busy_e),
    .cond_ex_e      (cond_ex_e),
    .branch_taken_e (branch_taken_e),
    .flags_q        (flags_q),
    .pc_wr_pending  (pc_wr_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [W-1:0] c, input logic [3:0] cc,
                               input logic mc, input logic st, input logic fl, input logic [3:0] af);
    valid_d     = v;
    ctrl_d      = c;
    cond_d      = cc;
    mc_d        = mc;
    stall_d     = st;
    flush_e     = fl;
    alu_flags_e = af;
  endtask

  // ARM-style: odd codes invert the even base condition; 111x is always.
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic b;
    case (c[3:1])
      3'd0: b = f[2];
      3'd1: b = f[1];
      3'd2: b = f[3];
      3'd3: b = f[0];
      3'd4: b = f[1] & ~f[2];
      3'd5: b = (f[3] == f[0]);
      3'd6: b = ~f[2] & (f[3] == f[0]);
      default: b = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return b ^ c[0];
  endfunction

  task automatic resetModel();
    m_valid = 1'b0;
    m_ctrl  = '0;
    m_cond  = '0;
    m_mc    = 1'b0;
    m_cnt   = 0;
    m_flags = '0;
    sb.delete();
    for (int i = 0; i < NSTAGES - 2; i++) sb.push_back('0);
  endtask

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic tick();
    logic         m_busy, m_pass, m_branch, m_pend;
    logic [W-1:0] s1_next, exp_w, n_ctrl;
    logic [3:0]   n_flags, n_cond;
    logic         n_valid, n_mc;
    int           n_cnt;
    #1;
    m_busy   = m_valid && m_mc && (m_cnt != 0);
    m_pass   = m_valid && cond_ref(m_cond, m_flags);
    m_branch = m_valid && m_ctrl[4] && m_pass && !m_busy;
    m_pend   = (valid_d & ctrl_d[1]) | m_ctrl[1];
    foreach (sb[i]) m_pend = m_pend | sb[i][1];
    checkOutput("busy_e", 32'(busy_e), 32'(m_busy));
    checkOutput("cond_ex_e", 32'(cond_ex_e), 32'(m_pass));
    checkOutput("branch_taken_e", 32'(branch_taken_e), 32'(m_branch));
    checkOutput("pc_wr_pending", 32'(pc_wr_pending), 32'(m_pend));
    checkOutput("ctrl_q_e", 32'(ctrl_q[W-1:0]), 32'(m_busy ? 7'd0 : m_ctrl));

    if (m_busy || !m_valid) s1_next = '0;
    else if (m_pass)        s1_next = m_ctrl;
    else                    s1_next = m_ctrl & 7'b1110001;

    n_flags = m_flags;
    if (m_valid && !m_busy && m_pass) begin
      if (m_ctrl[6]) n_flags[3:2] = alu_flags_e[3:2];
      if (m_ctrl[5]) n_flags[1:0] = alu_flags_e[1:0];
    end

    n_valid = m_valid; n_ctrl = m_ctrl; n_cond = m_cond; n_mc = m_mc; n_cnt = m_cnt;
    if (flush_e || (!m_busy && (stall_d || !valid_d))) begin
      n_valid = 1'b0; n_ctrl = '0; n_cond = '0; n_mc = 1'b0; n_cnt = 0;
    end else if (m_busy) begin
      n_cnt = m_cnt - 1;
    end else begin
      n_valid = 1'b1; n_ctrl = ctrl_d; n_cond = cond_d; n_mc = mc_d;
      n_cnt = mc_d ? MC_LAT - 1 : 0;
    end

    @(posedge clk);
    #1;
    m_valid = n_valid; m_ctrl = n_ctrl; m_cond = n_cond; m_mc = n_mc; m_cnt = n_cnt;
    m_flags = n_flags;
    sb.push_back(s1_next);
    exp_w = sb.pop_front();
    checkOutput("ctrl_q_w", 32'(ctrl_q[W*NSTAGES-1 -: W]), 32'(exp_w));
    for (int k = 1; k < NSTAGES - 1; k++) begin
      checkOutput("ctrl_q_mid", 32'(ctrl_q[k*W +: W]), 32'(sb[NSTAGES-2-k]));
    end
    checkOutput("flags_q", 32'(flags_q), 32'(m_flags));
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl_q"}, 32'(ctrl_q), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_e), 32'd0);
    checkOutput({tag, "_cond_ex"}, 32'(cond_ex_e), 32'd0);
    checkOutput({tag, "_branch"}, 32'(branch_taken_e), 32'd0);
    checkOutput({tag, "_flags"}, 32'(flags_q), 32'd0);
    checkOutput({tag, "_pc_wr"}, 32'(pc_wr_pending), 32'd0);
  endtask

  initial begin
    int         busy_cnt;
    logic [3:0] f0;

    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b1;
    #3 reset = 1'b0;
    resetModel();
    repeat (2) @(negedge clk);
    // pc_src in D must stay invisible while reset is low
    applyStimulus(1'b1, 7'b0000010, 4'b1110, 1'b0, 1'b0, 1'b0, 4'd0);
    #1 checkAllZero("reset");
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    reset = 1'b1;

    // Test 1: ADD reg_write AL walks to stage 1 at +2, stage 2 at +3
    $display("[TB] test 1: single ADD");
    applyStimulus(1'b1, 7'b0000100, 4'b1110, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    checkOutput("t1_stage1_rw", 32'(ctrl_q[W+2]), 32'd1);
    tick();
    checkOutput("t1_stage2_rw", 32'(ctrl_q[2*W+2]), 32'd1);

    // Test 2: EQ with Z=0 suppresses mem_write
    $display("[TB] test 2: failing EQ store");
    applyStimulus(1'b1, 7'b0001000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0100);
    tick();
    checkOutput("t2_cond_ex", 32'(cond_ex_e), 32'd0);
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    checkOutput("t2_stage1_mw", 32'(ctrl_q[W+3]), 32'd0);
    checkOutput("t2_flags", 32'(flags_q), 32'd0);

    // Test 3: DIV then ADD; ADD is held in D while E is busy
    $display("[TB] test 3: DIV then ADD");
    applyStimulus(1'b1, 7'b0000100, 4'b1110, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b1, 7'b0000101, 4'b1110, 1'b0, 1'b0, 1'b0, 4'd0);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy_e !== 1'b1) break;
      busy_cnt++;
      tick();
    end
    checkOutput("t3_busy_cycles", 32'(busy_cnt), 32'd3);
    tick();
    checkOutput("t3_stage1_div", 32'(ctrl_q[2*W-1:W]), 32'(7'b0000100));
    checkOutput("t3_e_add", 32'(ctrl_q[W-1:0]), 32'(7'b0000101));
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();

    // Test 4: flush on 2nd busy cycle of a flag-writing DIV
    $display("[TB] test 4: flush mid-DIV");
    f0 = flags_q;
    applyStimulus(1'b1, 7'b1100100, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b1111);
    tick();
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1111);
    tick();
    checkOutput("t4_busy_before", 32'(busy_e), 32'd1);
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b1, 4'b1111);
    tick();
    checkOutput("t4_busy_after", 32'(busy_e), 32'd0);
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1111);
    tick();
    checkOutput("t4_flags", 32'(flags_q), 32'(f0));
    checkOutput("t4_stage1", 32'(ctrl_q[2*W-1:W]), 32'd0);

    // Test 5: CMP writes 0110, following BNE is not taken
    $display("[TB] test 5: CMP then BNE");
    applyStimulus(1'b1, 7'b1100000, 4'b1110, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    applyStimulus(1'b1, 7'b0010000, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0110);
    tick();
    checkOutput("t5_flags", 32'(flags_q), 32'(4'b0110));
    checkOutput("t5_branch", 32'(branch_taken_e), 32'd0);
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();

    // Test 6: reset mid-DIV
    $display("[TB] test 6: reset mid-DIV");
    applyStimulus(1'b1, 7'b1100110, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b1111);
    tick();
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1111);
    tick();
    #2 reset = 1'b0;
    #1 checkAllZero("t6_in_reset");
    resetModel();
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0, 4'b1111);
    reset = 1'b1;
    #1 checkAllZero("t6_release");
    tick();
    tick();

    // Random traffic including stall/flush overlap with busy
    $display("[TB] random phase");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom % 4) != 0, 7'($urandom), 4'($urandom), ($urandom % 6) == 0,
                    ($urandom % 5) == 0, ($urandom % 11) == 0, 4'($urandom));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_gen.md
CTRL_PIPE_GEN -- requirements
Module: ctrl_pipe_gen

Interface
REQ-001 Parameter NSTAGES, 3, number of post-decode stages; stage 0 is E, stage NSTAGES-1 is W; legal range 3..8.
REQ-002 Parameter MC_LAT, 4, execute latency in cycles of a multicycle op (MUL/DIV class); legal range 1..16.
REQ-003 Port clk  in  1  single clock; every register updates on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port valid_d  in  1  decode stage holds a real instruction.
REQ-006 Port ctrl_d  in  7  decoded bundle {flag_write[1:0], branch, mem_write, reg_write, pc_src, mem_to_reg}.
REQ-007 Port cond_d  in  4  condition field of the instruction in D.
REQ-008 Port mc_d  in  1  instruction in D is multicycle.
REQ-009 Port stall_d  in  1  hazard unit holds D; E receives a bubble.
REQ-010 Port flush_e  in  1  E is cleared at the next edge.
REQ-011 Port alu_flags_e  in  4  NZCV produced by the ALU in E.
REQ-012 Port ctrl_q  out  7*NSTAGES  condition-gated bundle per stage, stage k at bits [7k+6:7k].
REQ-013 Port busy_e  out  1  E is occupied by an unfinished multicycle op; upstream must stall.
REQ-014 Port cond_ex_e  out  1  condition of the instruction in E passes.
REQ-015 Port branch_taken_e  out  1  branch in E resolves taken this cycle.
REQ-016 Port flags_q  out  4  architectural NZCV.
REQ-017 Port pc_wr_pending  out  1  a PC write is in flight in D or stages 0..NSTAGES-2.

Function
REQ-018 E load priority per edge: flush_e -> bubble; else busy_e -> hold; else stall_d or !valid_d -> bubble; else {ctrl_d, cond_d, mc_d}.
REQ-019 Stage k>=1 loads the gated output of stage k-1 every edge; downstream stages never stall.
REQ-020 E loading with mc_d=1 sets the counter to MC_LAT-1; it decrements each cycle while nonzero.
REQ-021 busy_e = E valid & mc & counter!=0; with MC_LAT=1, a multicycle op behaves as single-cycle.
REQ-022 While busy_e=1, stage 1 receives a bubble, not a copy of E.
REQ-023 cond_ex_e is evaluated from cond in E against flags_q using ARM codes EQ..AL; 1111 evaluates as always.
REQ-024 E completes in the cycle it is valid with busy_e=0; reg_write, mem_write and pc_src pass to stage 1 only if cond_ex_e=1.
REQ-025 branch_taken_e = E valid & branch & cond_ex_e & !busy_e.
REQ-026 On completion with cond_ex_e=1: flag_write[1] loads N,Z and flag_write[0] loads C,V from alu_flags_e; other bits hold.
REQ-027 ctrl_q for E is the ungated bundle, forced to 0 while busy_e=1.
REQ-028 pc_wr_pending = (valid_d & pc_src of ctrl_d) OR pc_src of stages 0..NSTAGES-2.
REQ-029 flush_e during a multicycle op aborts it: counter to 0, no flags update, bubble into stage 1.
REQ-030 flush_e together with busy_e: flush wins; stall_d together with busy_e: hold wins, and D is not lost.

Reset
REQ-031 While reset=0, all stages are bubbles (bundle 0, invalid), the counter is 0 and flags_q is 0000.
REQ-032 While reset=0, ctrl_q, busy_e, cond_ex_e, branch_taken_e and pc_wr_pending are 0.
REQ-033 Reset asserted mid-multicycle aborts the op immediately, with no flag or bundle leakage after release.

Structure
REQ-034 Package ctrl_pipe_pkg holds CTRL_W=7, bundle field indices, NZCV bit positions and the 4-bit condition-code constants.
REQ-035 Condition evaluation is one combinational sub-module, cond_eval (cond, flags -> pass), also reusable by other blocks.
REQ-036 Stage storage is a parametrised array indexed by stage number; no per-stage hand-written registers.

Verification
REQ-037 Test 1: single ADD, reg_write=1, AL, NSTAGES=3 -> reg_write appears in ctrl_q stage 1 at +2 cycles and stage 2 at +3.
REQ-038 Test 2: cond EQ with flags_q Z=0 and mem_write=1 -> cond_ex_e=0; stage 1 mem_write=0 and flags_q unchanged.
REQ-039 Test 3: MC_LAT=4 DIV followed by an ADD -> busy_e high for 3 cycles; stage 1 gets 3 bubbles, then DIV; ADD enters E after DIV.
REQ-040 Test 4: flush_e on the 2nd busy cycle of a DIV with flag_write=11 -> busy_e drops next cycle; flags_q unchanged; stage 1 receives only bubbles.
REQ-041 Test 5: CMP sets flag_write=11 with alu_flags_e=0110, then BNE in the next instruction -> flags_q=0110; branch_taken_e=0.
REQ-042 Test 6: reset low mid-DIV, then released -> all outputs 0, flags_q=0000 and busy_e=0 on the first cycle after release.
